// File: rtl/conv_pkg.sv
// Shared defaults and types for the 3x3 convolution window generator.
package conv_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_PIX_W = 12;

  typedef logic [DEF_PIX_W-1:0] pixel_t;
  typedef pixel_t [8:0]         window_t;

  // Counter/address width for a range of n values; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_delay.sv
// line_delay: enable-gated circular buffer that delays its input by exactly DEPTH accepted samples.
module line_delay
  import conv_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = cnt_w(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;

  // The slot about to be overwritten holds the sample written DEPTH accepts ago.
  assign dout = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (ptr_q == PTR_LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is deliberately left unreset; stale lines are masked by the row counter.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3 sliding window with frame_done on the last window.
// Optional macro WIN_COORD_OUT_EN adds win_x/win_y (window center) outputs.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic               sof,
  input  logic [PIX_W-1:0]   pix_in,
  output logic               win_valid,
  output logic [9*PIX_W-1:0] win,
`ifdef WIN_COORD_OUT_EN
  output logic [9:0]         win_x,
  output logic [8:0]         win_y,
`endif
  output logic               frame_done
);

  localparam int XW = cnt_w(IMG_W);
  localparam int YW = cnt_w(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0]      x_q, x_d, cur_x;
  logic [YW-1:0]      y_q, y_d, cur_y;
  logic [9*PIX_W-1:0] win_q, win_d;
  logic               win_valid_q, win_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [PIX_W-1:0]   line1_out;
  logic [PIX_W-1:0]   line2_out;

  line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_valid),
    .din  (pix_in),
    .dout (line1_out)
  );

  line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line2 (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_valid),
    .din  (line1_out),
    .dout (line2_out)
  );

  always_comb begin
    cur_x        = x_q;
    cur_y        = y_q;
    x_d          = x_q;
    y_d          = y_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (sof) begin
      cur_x = '0;
      cur_y = '0;
    end else begin
      cur_x = x_q;
      cur_y = y_q;
    end
    if (pix_valid) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          y_d = '0;
        end else begin
          y_d = cur_y + YW'(1);
        end
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
      // Shift columns left; the right column is filled from the two line delays and the live pixel.
      for (int r = 0; r < 3; r++) begin
        win_d[(r*3)*PIX_W   +: PIX_W] = win_q[(r*3+1)*PIX_W +: PIX_W];
        win_d[(r*3+1)*PIX_W +: PIX_W] = win_q[(r*3+2)*PIX_W +: PIX_W];
      end
      win_d[2*PIX_W +: PIX_W] = line2_out;
      win_d[5*PIX_W +: PIX_W] = line1_out;
      win_d[8*PIX_W +: PIX_W] = pix_in;
      win_valid_d  = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
      frame_done_d = win_valid_d && (cur_x == X_LAST) && (cur_y == Y_LAST);
    end else begin
      win_d = win_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

`ifdef WIN_COORD_OUT_EN
  logic [9:0] win_x_q, win_x_d;
  logic [8:0] win_y_q, win_y_d;

  // Center is one column and one row behind the pixel that completed the window.
  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (win_valid_d) begin
      win_x_d = 10'(cur_x) - 10'd1;
      win_y_d = 9'(cur_y) - 9'd1;
    end else begin
      win_x_d = win_x_q;
      win_y_d = win_y_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen against a frame-buffer reference model.
module tb_conv_window_gen;

  localparam int W = 640;
  localparam int H = 8;
  localparam int P = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pix_valid = 1'b0;
  logic           sof = 1'b0;
  logic [P-1:0]   pix_in = '0;
  logic           win_valid;
  logic           frame_done;
  logic [9*P-1:0] win;
`ifdef WIN_COORD_OUT_EN
  logic [9:0]     win_x;
  logic [8:0]     win_y;
`endif

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .pix_in     (pix_in),
    .win_valid  (win_valid),
    .win        (win),
`ifdef WIN_COORD_OUT_EN
    .win_x      (win_x),
    .win_y      (win_y),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the frame as a 2-D image plus the raster position of the next pixel.
  int             img [H][W];
  int             mx, my;
  logic [9*P-1:0] last_win;
  bit             last_known;
  bit             exp_wv, exp_fd;
  int             exp_cx, exp_cy;
  int             cnt_wv, cnt_fd, fd_cx, fd_cy;

  typedef struct {
    bit v;
    bit s;
    bit exp_wv;
    int exp_center;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pat(input int x, input int y);
    return (y * W + x) % 4096;
  endfunction

  function automatic int rnd_pix();
    return int'($urandom_range(0, 4095));
  endfunction

  task automatic step(input bit v, input bit s, input int p);
    logic [9*P-1:0] ew;
    ew     = '0;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    pix_valid = v;
    sof       = s;
    pix_in    = P'(p);
    if (v) begin
      if (s) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = p;
      if (mx >= 2 && my >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew[(r*3+c)*P +: P] = P'(img[my-2+r][mx-2+c]);
        exp_wv     = 1'b1;
        exp_cx     = mx - 1;
        exp_cy     = my - 1;
        exp_fd     = (mx == W-1) && (my == H-1);
        last_win   = ew;
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    @(posedge clk);
    #1;
    check("win_valid", 128'(win_valid), 128'(exp_wv));
    check("frame_done", 128'(frame_done), 128'(exp_fd));
    if (win_valid) cnt_wv++;
    if (frame_done) begin
      cnt_fd++;
      fd_cx = exp_cx;
      fd_cy = exp_cy;
    end
    if (exp_wv || (!v && last_known)) check("win", 128'(win), 128'(last_win));
`ifdef WIN_COORD_OUT_EN
    if (exp_wv) begin
      check("win_x", 128'(win_x), 128'(exp_cx));
      check("win_y", 128'(win_y), 128'(exp_cy));
    end
`endif
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    sof       = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check("rst_win", 128'(win), 128'(0));
    check("rst_win_valid", 128'(win_valid), 128'(0));
    check("rst_frame_done", 128'(frame_done), 128'(0));
`ifdef WIN_COORD_OUT_EN
    check("rst_win_x", 128'(win_x), 128'(0));
    check("rst_win_y", 128'(win_y), 128'(0));
`endif
    rst        = 1'b0;
    mx         = 0;
    my         = 0;
    last_win   = '0;
    last_known = 1'b1;
  endtask

  task automatic send_frame(input bit gaps);
    cnt_wv = 0;
    cnt_fd = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gaps) begin
          while ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom_range(0, 1)), rnd_pix());
        end
        step(1'b1, (x == 0) && (y == 0), pat(x, y));
        if (x == 2 && y == 2) begin
          check("first_wv", 128'(win_valid), 128'(1));
          check("first_wv_count", 128'(cnt_wv), 128'(1));
          check("win0", 128'(win[0 +: P]), 128'(0));
          check("win4", 128'(win[4*P +: P]), 128'(641));
          check("win8", 128'(win[8*P +: P]), 128'(1282));
        end
      end
    end
    check("frame_wv_count", 128'(cnt_wv), 128'((W-2)*(H-2)));
    check("frame_fd_count", 128'(cnt_fd), 128'(1));
    check("frame_fd_cx", 128'(fd_cx), 128'(W-2));
    check("frame_fd_cy", 128'(fd_cy), 128'(H-2));
  endtask

  initial begin
    // Row-boundary vectors, applied once the stream sits at (639,5).
    tbl[0] = '{v: 1'b1, s: 1'b0, exp_wv: 1'b1, exp_center: pat(638, 4)};
    tbl[1] = '{v: 1'b1, s: 1'b0, exp_wv: 1'b0, exp_center: 0};
    tbl[2] = '{v: 1'b1, s: 1'b0, exp_wv: 1'b0, exp_center: 0};
    tbl[3] = '{v: 1'b0, s: 1'b0, exp_wv: 1'b0, exp_center: 0};
    tbl[4] = '{v: 1'b1, s: 1'b0, exp_wv: 1'b1, exp_center: pat(1, 5)};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    send_frame(1'b0);
    send_frame(1'b1);

    // Row boundary.
    step(1'b1, 1'b1, pat(0, 0));
    while (!(mx == W-1 && my == 5)) step(1'b1, 1'b0, pat(mx, my));
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, pat(mx, my));
      check("tbl_wv", 128'(win_valid), 128'(tbl[i].exp_wv));
      if (tbl[i].exp_wv) check("tbl_center", 128'(win[4*P +: P]), 128'(tbl[i].exp_center));
    end

    // Mid-frame sof restarts counting with stale line contents.
    while (!(mx == 300 && my == 6)) step(1'b1, 1'b0, rnd_pix());
    step(1'b1, 1'b1, rnd_pix());
    cnt_wv = 0;
    while (!(mx == 2 && my == 2)) step(1'b1, 1'b0, rnd_pix());
    check("sof_no_wv", 128'(cnt_wv), 128'(0));
    step(1'b1, 1'b0, rnd_pix());
    check("sof_first_wv", 128'(win_valid), 128'(1));

    // Mid-frame reset; counting restarts without sof.
    while (!(mx == 100 && my == 3)) step(1'b1, 1'b0, rnd_pix());
    do_reset();
    cnt_wv = 0;
    while (!(mx == 2 && my == 2)) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, rnd_pix());
      else step(1'b1, 1'b0, rnd_pix());
    end
    check("rst_no_wv", 128'(cnt_wv), 128'(0));
    step(1'b1, 1'b0, rnd_pix());
    check("rst_first_wv", 128'(win_valid), 128'(1));
    check("rst_first_center", 128'(win[4*P +: P]), 128'(img[1][1]));
`ifdef WIN_COORD_OUT_EN
    check("rst_first_win_x", 128'(win_x), 128'(1));
    check("rst_first_win_y", 128'(win_y), 128'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
